// File: rtl/note_track.sv
// note_track: falling-note grid, song ROM fetch, hit judgement and score/combo keeping
module note_track #(
    parameter int NROWS  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 load_song,
    input  logic                 load_note,
    input  logic                 shift,
    input  logic                 logic_in,
    input  logic                 reset_score,
    input  logic [3:0]           key,
    output logic [ADDR_W-1:0]    song_addr,
    input  logic [4:0]           song_note,
    output logic                 songdone,
    output logic [4*NROWS-1:0]   grid,
    output logic [3:0]           hit_lanes,
    output logic [3:0]           miss_lanes,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo
);
    logic        playing, end_flag;
    logic [3:0]  pending, latch;
    logic [3:0]  k, n, hit, miss;
    logic [2:0]  hit_cnt;
    logic [16:0] score_sum;
    logic [8:0]  combo_sum;
    logic [15:0] score_new;
    logic [7:0]  combo_new, max_new;

    // a press counts if seen any time since the last judgement or right now
    always_comb begin
        k         = latch | key;
        n         = grid[4*(NROWS-1) +: 4];
        hit       = n & k;
        miss      = n ^ k;
        hit_cnt   = {2'b0, hit[0]} + {2'b0, hit[1]} + {2'b0, hit[2]} + {2'b0, hit[3]};
        score_sum = {1'b0, score} + {14'b0, hit_cnt};
        combo_sum = {1'b0, combo} + {6'b0, hit_cnt};
        score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        combo_new = (|miss) ? 8'd0 : (combo_sum[8] ? 8'hFF : combo_sum[7:0]);
        max_new   = (combo_new > max_combo) ? combo_new : max_combo;
    end

    assign songdone = playing & (song_note[4] | end_flag);

    // song state, grid, key latch and scoring; load_song overrides all other commands
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            playing    <= 1'b0;
            end_flag   <= 1'b0;
            pending    <= '0;
            latch      <= '0;
            song_addr  <= '0;
            grid       <= '0;
            hit_lanes  <= '0;
            miss_lanes <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
        end else if (load_song) begin
            playing    <= 1'b1;
            end_flag   <= 1'b0;
            pending    <= '0;
            latch      <= '0;
            song_addr  <= '0;
            grid       <= '0;
            hit_lanes  <= '0;
            miss_lanes <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
        end else begin
            latch <= (playing && logic_in) ? 4'b0 : (latch | key);
            if (playing) begin
                if (shift) begin
                    grid    <= {grid[4*NROWS-5:0], pending};
                    pending <= '0;
                end
                if (load_note && !song_note[4]) begin
                    pending <= song_note[3:0];
                    if (&song_addr) end_flag <= 1'b1;
                    else song_addr <= song_addr + 1'b1;
                end
                if (reset_score) begin
                    hit_lanes  <= '0;
                    miss_lanes <= '0;
                end
                if (logic_in) begin
                    hit_lanes  <= hit;
                    miss_lanes <= miss;
                    score      <= score_new;
                    combo      <= combo_new;
                    max_combo  <= max_new;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_track.sv
// tb_note_track: table-driven directed checks plus multi-cycle corner sequences
module tb_note_track;
    localparam logic [4:0] LS = 5'b10000, LN = 5'b01000, SH = 5'b00100, LI = 5'b00010, RS = 5'b00001;

    logic        clock = 1'b0, resetn = 1'b0;
    logic        load_song = 0, load_note = 0, shift = 0, logic_in = 0, reset_score = 0;
    logic [3:0]  key = 0;
    logic [4:0]  song_note = 0;
    logic [7:0]  song_addr;
    logic        songdone;
    logic [31:0] grid;
    logic [3:0]  hit_lanes, miss_lanes;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;

    int tests = 0, fails = 0;

    typedef struct {
        logic [4:0]  cmd;
        logic [3:0]  key;
        logic [4:0]  note;
        logic        done;
        logic [7:0]  addr;
        logic [31:0] grid;
        logic [3:0]  hit, miss;
        logic [15:0] sc;
        logic [7:0]  co, mc;
    } vec_t;
    vec_t tbl[$];

    note_track dut (
        .clock(clock), .resetn(resetn), .load_song(load_song), .load_note(load_note),
        .shift(shift), .logic_in(logic_in), .reset_score(reset_score), .key(key),
        .song_addr(song_addr), .song_note(song_note), .songdone(songdone), .grid(grid),
        .hit_lanes(hit_lanes), .miss_lanes(miss_lanes), .score(score), .combo(combo),
        .max_combo(max_combo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cmd, input logic [3:0] k, input logic [4:0] note);
        {load_song, load_note, shift, logic_in, reset_score} = cmd;
        key = k;
        song_note = note;
    endtask

    task automatic cyc(input logic [4:0] cmd, input logic [3:0] k, input logic [4:0] note);
        drive(cmd, k, note);
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [4:0] cmd, input logic [3:0] k, input logic [4:0] note,
                       input logic done, input logic [7:0] addr, input logic [31:0] g,
                       input logic [3:0] hit, input logic [3:0] miss, input logic [15:0] sc,
                       input logic [7:0] co, input logic [7:0] mc);
        vec_t v;
        v.cmd = cmd; v.key = k; v.note = note; v.done = done; v.addr = addr; v.grid = g;
        v.hit = hit; v.miss = miss; v.sc = sc; v.co = co; v.mc = mc;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input int idx, input logic [7:0] addr, input logic [31:0] g,
                           input logic [3:0] hit, input logic [3:0] miss, input logic [15:0] sc,
                           input logic [7:0] co, input logic [7:0] mc);
        chk("addr", idx, 32'(song_addr), 32'(addr));
        chk("grid", idx, grid, g);
        chk("hit", idx, 32'(hit_lanes), 32'(hit));
        chk("miss", idx, 32'(miss_lanes), 32'(miss));
        chk("score", idx, 32'(score), 32'(sc));
        chk("combo", idx, 32'(combo), 32'(co));
        chk("max_combo", idx, 32'(max_combo), 32'(mc));
    endtask

    initial begin
        int sm, cm;
        add(LS, 0, 5'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        add(LN, 0, 5'h01, 0, 1, 0, 0, 0, 0, 0, 0);
        add(LN, 0, 5'h02, 0, 2, 0, 0, 0, 0, 0, 0);
        add(LN, 0, 5'h10, 1, 2, 0, 0, 0, 0, 0, 0);
        add(SH, 0, 5'h00, 0, 2, 32'h2, 0, 0, 0, 0, 0);
        add(LS | SH, 0, 5'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        add(LN, 0, 5'h09, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(SH, 0, 5'h00, 0, 1, 32'h9 << (4 * i), 0, 0, 0, 0, 0);
        add(SH, 0, 5'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        add(LN, 4'b0001, 5'h05, 0, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(SH, 0, 5'h00, 0, 2, 32'h5 << (4 * i), 0, 0, 0, 0, 0);
        add(0, 4'b0100, 5'h00, 0, 2, 32'h50000000, 0, 0, 0, 0, 0);
        add(LI, 4'b0100, 5'h00, 0, 2, 32'h50000000, 4'b0101, 0, 2, 2, 2);
        add(LN, 0, 5'h03, 0, 3, 32'h50000000, 4'b0101, 0, 2, 2, 2);
        for (int i = 0; i < 8; i++) add(SH, 0, 5'h00, 0, 3, 32'h3 << (4 * i), 4'b0101, 0, 2, 2, 2);
        add(LI, 4'b1000, 5'h00, 0, 3, 32'h30000000, 0, 4'b1011, 2, 0, 2);
        add(LN | RS, 0, 5'h06, 0, 4, 32'h30000000, 0, 0, 2, 0, 2);
        add(SH, 0, 5'h00, 0, 4, 32'h6, 0, 0, 2, 0, 2);

        drive(0, 0, 5'h10);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn = 1'b1;
        chk("reset_done", 0, 32'(songdone), 0);
        chk_all(-1, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].cmd, tbl[i].key, tbl[i].note);
            #1;
            chk("songdone", i, 32'(songdone), 32'(tbl[i].done));
            @(posedge clock); #1;
            chk_all(i, tbl[i].addr, tbl[i].grid, tbl[i].hit, tbl[i].miss, tbl[i].sc, tbl[i].co, tbl[i].mc);
        end

        cyc(LS, 0, 0);
        cyc(LN, 0, 5'h0F);
        for (int i = 0; i < 8; i++) cyc(SH, 0, 0);
        chk("sat_grid", 0, grid, 32'hF0000000);
        sm = 0; cm = 0;
        for (int i = 0; i < 16385; i++) begin
            cyc((i == 0) ? (LI | RS) : LI, 4'hF, 0);
            sm = (sm + 4 > 65535) ? 65535 : sm + 4;
            cm = (cm + 4 > 255) ? 255 : cm + 4;
            if (i == 0) chk("li_rs_hit", i, 32'(hit_lanes), 32'hF);
            chk("sat_score", i, 32'(score), 32'(sm));
            chk("sat_combo", i, 32'(combo), 32'(cm));
            chk("sat_max", i, 32'(max_combo), 32'(cm));
        end
        chk("score_ffff", 0, 32'(score), 32'hFFFF);
        cyc(LI, 0, 0);
        chk("peak_combo", 0, 32'(combo), 0);
        chk("peak_max", 0, 32'(max_combo), 32'hFF);
        chk("peak_miss", 0, 32'(miss_lanes), 32'hF);
        chk("peak_score", 0, 32'(score), 32'hFFFF);

        cyc(LS, 0, 0);
        for (int i = 0; i < 255; i++) cyc(LN, 0, 0);
        chk("addr_top", 0, 32'(song_addr), 32'hFF);
        drive(LN, 0, 5'h0F);
        #1;
        chk("done_pre_end", 0, 32'(songdone), 0);
        @(posedge clock); #1;
        drive(0, 0, 0);
        #1;
        chk("addr_nowrap", 0, 32'(song_addr), 32'hFF);
        chk("done_endflag", 0, 32'(songdone), 1);
        cyc(SH, 0, 0);
        chk("grid_end", 0, grid, 32'hF);

        drive(0, 0, 5'h10);
        resetn = 1'b0;
        #1;
        chk("async_done", 0, 32'(songdone), 0);
        chk_all(-2, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        drive(LN, 0, 5'h10);
        #1;
        chk("idle_done", 0, 32'(songdone), 0);
        @(posedge clock); #1;
        cyc(LN | SH, 0, 5'h01);
        chk("idle_addr", 0, 32'(song_addr), 0);
        chk("idle_grid", 0, grid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
